link_transmitter: RTL and testbench

LINK_TRANSMITTER -- requirements
Module: link_transmitter

---
 rtl/link_transmitter_pkg.sv | 35 +++
 rtl/link_transmitter_byte_fifo.sv | 83 ++++++++
 rtl/link_transmitter.sv | 205 ++++++++++++++++++++
 tb/tb_link_transmitter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_transmitter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : link_transmitter_pkg
// Description : Shared serial-link definitions used by both the transmitter
//               and the receiver: framing FSM states, frame constants and the
//               parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package link_transmitter_pkg;

    // Framing FSM states. The receiver walks the same sequence, so the
    // encoding lives here rather than in either end of the link.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } link_state_t;

    // Payload bits per frame.
    localparam int DATA_BITS = 8;

    // Line levels for the framing bits; the line rests at the stop level.
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage : link_transmitter_pkg
`default_nettype wire

// File: rtl/link_transmitter_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous byte FIFO with push/pop and occupancy count.
//               The head byte is presented combinationally on o_data.
//               Push is ignored when full, pop is ignored when empty; a push
//               and a pop on the same edge leave the level unchanged.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset
//               i_push   - write i_data this edge (if not full)
//               i_data   - byte to write
//               i_pop    - discard head byte this edge (if not empty)
//               o_data   - current head byte
//               o_empty  - no bytes stored
//               o_level  - number of bytes stored, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam logic [c_lw-1:0] c_full_level = c_lw'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_lw-1:0] r_level;

    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (r_level == c_full_level);
    assign o_empty   = (r_level == '0);
    // A full FIFO refuses the push even if the head is popped on the same
    // edge, so acceptance never depends on the consumer's decision.
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && !o_empty;

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural rollover.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + c_lw'(1);
                2'b01:   r_level <= r_level - c_lw'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/link_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : link_transmitter
// Description : Buffers encrypted bytes and sends them as serial frames:
//               start(0), 8 data bits LSB first, optional even parity,
//               stop(1). Every bit is held BIT_CYCLES clocks. Frames queued
//               in the FIFO are sent back to back with no idle bit.
// Ports       : clock      - clock, rising edge
//               reset      - asynchronous active-high reset
//               in_data    - byte offered by the encrypter stage
//               in_valid   - in_data is valid
//               in_ready   - a byte can be accepted this cycle
//               serial_out - registered serial line, idles high
//               busy       - frame in progress or bytes buffered
//               frame_done - one-cycle pulse after each completed frame
//               fifo_level - bytes currently buffered
// Revision    : 1.0 - initial release
// ============================================================================
module link_transmitter #(
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import link_transmitter_pkg::*;

    localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_lvl_w-1:0] c_depth      = c_lvl_w'(FIFO_DEPTH);
    localparam logic [7:0]         c_timer_last = 8'(BIT_CYCLES - 1);
    localparam logic [2:0]         c_last_bit   = 3'(DATA_BITS - 1);
    localparam link_state_t        c_after_data = (PARITY_EN != 0) ? PARITY : STOP;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    link_state_t r_state;
    logic [7:0]  r_timer;
    logic [2:0]  r_index;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic        r_serial;
    logic        r_frame_done;

    link_state_t w_state_next;
    logic [7:0]  w_timer_next;
    logic [2:0]  w_index_next;
    logic [7:0]  w_shift_next;
    logic        w_parity_next;
    logic        w_serial_next;
    logic        w_frame_done_next;
    logic        w_timer_done;

    // FIFO interface
    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_head;
    logic               w_empty;
    logic [c_lvl_w-1:0] w_level;

    // ------------------------------------------------------------------
    // Byte buffer
    // ------------------------------------------------------------------
    byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign in_ready   = (w_level < c_depth);
    assign w_push     = in_valid && in_ready;
    assign fifo_level = w_level;
    assign busy       = (r_state != IDLE) || !w_empty;
    assign serial_out = r_serial;
    assign frame_done = r_frame_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_index      <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_serial     <= IDLE_LEVEL;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_index      <= w_index_next;
            r_shift      <= w_shift_next;
            r_parity     <= w_parity_next;
            r_serial     <= w_serial_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and line logic
    // ------------------------------------------------------------------
    // The timer counts 0..BIT_CYCLES-1 within a bit and reloads to 0 at
    // every bit boundary, so each bit occupies exactly BIT_CYCLES clocks.
    assign w_timer_done = (r_timer == c_timer_last);

    always_comb begin
        w_state_next      = r_state;
        w_timer_next      = r_timer + 8'd1;
        w_index_next      = r_index;
        w_shift_next      = r_shift;
        w_parity_next     = r_parity;
        w_pop             = 1'b0;
        w_frame_done_next = 1'b0;
        w_serial_next     = IDLE_LEVEL;

        case (r_state)
            IDLE: begin
                w_timer_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_timer_done) begin
                    w_timer_next = '0;
                    w_index_next = '0;
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_timer_done) begin
                    w_timer_next = '0;
                    // The index rolls 7->0 as the last bit leaves, ready
                    // for the next frame without an explicit clear.
                    w_index_next = r_index + 3'd1;
                    if (r_index == c_last_bit) begin
                        w_state_next = c_after_data;
                    end else begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                    end
                end
            end
            PARITY: begin
                if (w_timer_done) begin
                    w_timer_next = '0;
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_timer_done) begin
                    w_timer_next      = '0;
                    w_frame_done_next = 1'b1;
                    // Chain straight into the next start bit when data is
                    // waiting; no idle bit is inserted between frames.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_timer_next = '0;
                w_state_next = IDLE;
            end
        endcase

        // Capture the head byte and its parity together with the pop.
        if (w_pop) begin
            w_shift_next  = w_head;
            w_parity_next = even_parity(w_head);
        end

        // The line is registered from the level of the state being entered,
        // so serial_out changes only on clock edges.
        case (w_state_next)
            START:   w_serial_next = START_LEVEL;
            DATA:    w_serial_next = w_shift_next[0];
            PARITY:  w_serial_next = w_parity_next;
            STOP:    w_serial_next = STOP_LEVEL;
            default: w_serial_next = IDLE_LEVEL;
        endcase
    end

endmodule : link_transmitter
`default_nettype wire

// File: tb/tb_link_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_transmitter
// Description : Self-checking bench for link_transmitter. Two instances:
//               dut0 (BIT_CYCLES=4, parity on, depth 4) and dut1
//               (BIT_CYCLES=1, parity off, depth 2). Frame monitors capture
//               the serial line and compare each frame with an expected
//               line waveform from a table or from a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_transmitter;

    localparam int BC0 = 4, PE0 = 1, D0 = 4;
    localparam int BC1 = 1, PE1 = 0, D1 = 2;
    localparam int LEN0 = (10 + PE0) * BC0;
    localparam int LEN1 = (10 + PE1) * BC1;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_data0, in_data1;
    logic       in_valid0, in_valid1;
    logic       in_ready0, in_ready1;
    logic       serial0, serial1;
    logic       busy0, busy1;
    logic       fd0, fd1;
    logic [2:0] lvl0;
    logic [1:0] lvl1;

    link_transmitter #(.BIT_CYCLES(BC0), .PARITY_EN(PE0), .FIFO_DEPTH(D0)) dut0 (
        .clock(clock), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .serial_out(serial0), .busy(busy0),
        .frame_done(fd0), .fifo_level(lvl0));

    link_transmitter #(.BIT_CYCLES(BC1), .PARITY_EN(PE1), .FIFO_DEPTH(D1)) dut1 (
        .clock(clock), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .serial_out(serial1), .busy(busy1),
        .frame_done(fd1), .fifo_level(lvl1));

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    int starts0[$];
    int fdc0[$];
    int frames0 = 0, frames1 = 0;
    int fd_cnt0 = 0, fd_cnt1 = 0;
    bit fd_prev0 = 1'b0, fd_prev1 = 1'b0;
    bit mon_en0 = 1'b1, mon_en1 = 1'b1;
    bit mon_busy0 = 1'b0, mon_busy1 = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] levels;   // bit k = line level of frame bit k (start first)
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: builds the sampled line waveform from the framing
    // rules directly (start 0, data LSB first, even parity, stop 1).
    function automatic logic [63:0] model_frame(input logic [7:0] d, input int bc, input int pe);
        logic [63:0] v;
        int ones;
        int b;
        int lvl;
        v = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        for (int t = 0; t < (10 + pe) * bc; t++) begin
            b = t / bc;
            if (b == 0)                  lvl = 0;
            else if (b <= 8)             lvl = (int'(d) >> (b - 1)) & 1;
            else if (pe != 0 && b == 9)  lvl = ones % 2;
            else                         lvl = 1;
            v[t] = lvl[0];
        end
        return v;
    endfunction

    // Stretches a table row of per-bit levels to per-clock samples.
    function automatic logic [63:0] expand(input logic [10:0] lv, input int bc, input int pe);
        logic [10:0] seq;
        logic [63:0] v;
        v = '0;
        seq = (pe != 0) ? lv : {1'b0, lv[10], lv[8:0]};
        for (int t = 0; t < (10 + pe) * bc; t++) v[t] = seq[t / bc];
        return v;
    endfunction

    task automatic push0(input logic [7:0] d, input bit enq, input logic [63:0] expv);
        int n;
        n = 0;
        in_data0  = d;
        in_valid0 = 1'b1;
        while (in_ready0 !== 1'b1 && n < 2000) begin @(negedge clock); n++; end
        check("push0_ready", 64'(n < 2000), 64'd1);
        if (enq) exp_q0.push_back(expv);
        @(negedge clock);
        in_valid0 = 1'b0;
    endtask

    task automatic push1(input logic [7:0] d, input logic [63:0] expv);
        int n;
        n = 0;
        in_data1  = d;
        in_valid1 = 1'b1;
        while (in_ready1 !== 1'b1 && n < 2000) begin @(negedge clock); n++; end
        check("push1_ready", 64'(n < 2000), 64'd1);
        exp_q1.push_back(expv);
        @(negedge clock);
        in_valid1 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy0 || busy1 ||
                mon_busy0 || mon_busy1) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check(name, 64'(n < 5000), 64'd1);
        repeat (2) @(negedge clock);
    endtask

    // ---------------- frame monitor, dut0 ----------------
    initial begin : mon0
        bit resume;
        logic [63:0] cap;
        resume = 1'b0;
        forever begin
            if (!resume) @(negedge clock);
            resume = 1'b0;
            if (mon_en0 && reset === 1'b0 && serial0 === 1'b0) begin
                mon_busy0 = 1'b1;
                starts0.push_back(cyc);
                cap = '0;
                cap[0] = serial0;
                for (int t = 1; t < LEN0; t++) begin @(negedge clock); cap[t] = serial0; end
                @(negedge clock);
                check("frame_done_at_end0", 64'(fd0), 64'd1);
                check("frame_expected0", 64'(exp_q0.size() != 0), 64'd1);
                if (exp_q0.size() != 0) check("frame_bits0", cap, exp_q0.pop_front());
                frames0++;
                mon_busy0 = 1'b0;
                resume = 1'b1;   // the next start bit may already be on the line
            end
        end
    end

    // ---------------- frame monitor, dut1 ----------------
    initial begin : mon1
        bit resume;
        logic [63:0] cap;
        resume = 1'b0;
        forever begin
            if (!resume) @(negedge clock);
            resume = 1'b0;
            if (mon_en1 && reset === 1'b0 && serial1 === 1'b0) begin
                mon_busy1 = 1'b1;
                cap = '0;
                cap[0] = serial1;
                for (int t = 1; t < LEN1; t++) begin @(negedge clock); cap[t] = serial1; end
                @(negedge clock);
                check("frame_done_at_end1", 64'(fd1), 64'd1);
                check("frame_expected1", 64'(exp_q1.size() != 0), 64'd1);
                if (exp_q1.size() != 0) check("frame_bits1", cap, exp_q1.pop_front());
                frames1++;
                mon_busy1 = 1'b0;
                resume = 1'b1;
            end
        end
    end

    // ---------------- frame_done pulse watcher ----------------
    initial begin : fdmon
        forever begin
            @(negedge clock);
            if (fd0 === 1'b1) begin
                check("fd0_single_cycle", 64'(fd_prev0), 64'd0);
                fd_cnt0++;
                fdc0.push_back(cyc);
            end
            if (fd1 === 1'b1) begin
                check("fd1_single_cycle", 64'(fd_prev1), 64'd0);
                fd_cnt1++;
            end
            fd_prev0 = fd0;
            fd_prev1 = fd1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int n, acc, k, fdb;
        logic [7:0] d;
        logic [7:0] six[6];

        tbl[0] = '{8'h2B, 11'b1_0_00101011_0};
        tbl[1] = '{8'h00, 11'b1_0_00000000_0};
        tbl[2] = '{8'hFF, 11'b1_0_11111111_0};
        tbl[3] = '{8'h80, 11'b1_1_10000000_0};
        tbl[4] = '{8'h01, 11'b1_1_00000001_0};
        tbl[5] = '{8'h3C, 11'b1_0_00111100_0};
        tbl[6] = '{8'hFE, 11'b1_1_11111110_0};
        tbl[7] = '{8'hA5, 11'b1_0_10100101_0};
        six[0] = 8'h11; six[1] = 8'h22; six[2] = 8'h33;
        six[3] = 8'h44; six[4] = 8'h5A; six[5] = 8'h66;

        reset = 1'b1;
        in_data0 = '0; in_valid0 = 1'b0;
        in_data1 = '0; in_valid1 = 1'b0;
        repeat (2) @(negedge clock);

        // Reset state
        check("rst_serial0", 64'(serial0), 64'd1);
        check("rst_fd0", 64'(fd0), 64'd0);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_level0", 64'(lvl0), 64'd0);
        check("rst_serial1", 64'(serial1), 64'd1);
        check("rst_level1", 64'(lvl1), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready0", 64'(in_ready0), 64'd1);
        check("post_rst_ready1", 64'(in_ready1), 64'd1);

        // Single frame 0x2B: one clock of buffering, then the 44-clock frame
        push0(tbl[0].data, 1'b1, expand(tbl[0].levels, BC0, PE0));
        check("2B_buffered_serial", 64'(serial0), 64'd1);
        check("2B_buffered_level", 64'(lvl0), 64'd1);
        check("2B_buffered_busy", 64'(busy0), 64'd1);
        @(negedge clock);
        check("2B_popped_level", 64'(lvl0), 64'd0);
        check("2B_start_bit", 64'(serial0), 64'd0);
        wait_idle("idle_2B");
        check("2B_fd_count", 64'(fd_cnt0), 64'd1);
        check("2B_frame_len", 64'(fdc0[fdc0.size()-1] - starts0[starts0.size()-1]), 64'd44);

        // Back-to-back 0x00, 0xFF: no idle gap between the frames
        fdb = fd_cnt0;
        push0(tbl[1].data, 1'b1, expand(tbl[1].levels, BC0, PE0));
        push0(tbl[2].data, 1'b1, expand(tbl[2].levels, BC0, PE0));
        wait_idle("idle_b2b");
        check("b2b_fd_count", 64'(fd_cnt0 - fdb), 64'd2);
        check("b2b_start_gap", 64'(starts0[starts0.size()-1] - starts0[starts0.size()-2]), 64'd44);
        check("b2b_fd_gap", 64'(fdc0[fdc0.size()-1] - fdc0[fdc0.size()-2]), 64'd44);

        // Table: every entry through both configurations
        for (int i = 0; i < 8; i++) push0(tbl[i].data, 1'b1, expand(tbl[i].levels, BC0, PE0));
        wait_idle("idle_tbl0");
        // dut1 starts with 0x80: the 10-clock frame 0,0,0,0,0,0,0,0,1,1
        push1(tbl[3].data, expand(tbl[3].levels, BC1, PE1));
        wait_idle("idle_80");
        check("80_fd_count1", 64'(fd_cnt1), 64'd1);
        for (int i = 0; i < 8; i++) push1(tbl[i].data, expand(tbl[i].levels, BC1, PE1));
        wait_idle("idle_tbl1");

        // Hold in_valid for six bytes: the FIFO fills after five acceptances
        acc = 0;
        k = 0;
        while (acc < 6 && k < 1000) begin
            if (k == 5) begin
                check("six_level_full", 64'(lvl0), 64'd4);
                check("six_ready_low", 64'(in_ready0), 64'd0);
                check("six_accepted", 64'(acc), 64'd5);
            end
            in_data0  = six[acc];
            in_valid0 = 1'b1;
            if (in_ready0 === 1'b1) begin
                exp_q0.push_back(model_frame(six[acc], BC0, PE0));
                acc++;
            end
            @(negedge clock);
            k++;
        end
        in_valid0 = 1'b0;
        check("six_all_accepted", 64'(acc), 64'd6);
        wait_idle("idle_six");

        // Asynchronous reset during data bit 3 of 0x55, with 0x33 queued
        mon_en0 = 1'b0;
        @(negedge clock);
        fdb = fd_cnt0;
        push0(8'h55, 1'b0, '0);
        n = 0;
        while (serial0 !== 1'b0 && n < 100) begin @(negedge clock); n++; end
        check("rst55_start_seen", 64'(n < 100), 64'd1);
        push0(8'h33, 1'b0, '0);
        repeat (16) @(negedge clock);
        check("rst55_bit3_level", 64'(serial0), 64'd0);
        check("rst55_level_before", 64'(lvl0), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst55_serial_async", 64'(serial0), 64'd1);
        check("rst55_level_async", 64'(lvl0), 64'd0);
        check("rst55_busy_async", 64'(busy0), 64'd0);
        check("rst55_fd_async", 64'(fd0), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst55_ready_after", 64'(in_ready0), 64'd1);
        repeat (60) @(negedge clock);
        check("rst55_no_fd", 64'(fd_cnt0 - fdb), 64'd0);
        check("rst55_stays_idle", 64'({busy0, serial0}), 64'b01);
        mon_en0 = 1'b1;
        push0(tbl[7].data, 1'b1, expand(tbl[7].levels, BC0, PE0));
        wait_idle("idle_A5");
        check("A5_fd_count", 64'(fd_cnt0 - fdb), 64'd1);

        // Randomized traffic against the frame model
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 6)) @(negedge clock);
            push0(d, 1'b1, model_frame(d, BC0, PE0));
        end
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 12)) @(negedge clock);
            push1(d, model_frame(d, BC1, PE1));
        end
        wait_idle("idle_random");

        check("final_q0_empty", 64'(exp_q0.size()), 64'd0);
        check("final_q1_empty", 64'(exp_q1.size()), 64'd0);
        check("final_fd_vs_frames0", 64'(fd_cnt0), 64'(frames0));
        check("final_fd_vs_frames1", 64'(fd_cnt1), 64'(frames1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin : watchdog
        #2000000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_link_transmitter
`default_nettype wire
